// File: rtl/counter_sequencer.sv
// counter_sequencer: run controller for a toggle-enable up-counter (start/pause/stop, terminal count, auto-reload).
// Optional PRESCALE_EN macro divides the count-advance strobe by PRESCALE_DIV.
module counter_sequencer #(
  parameter int WIDTH        = 4,
  parameter int PRESCALE_DIV = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic             pause_i,
  input  logic             auto_reload_i,
  input  logic [WIDTH-1:0] limit_i,
  output logic             t_en_o,
  output logic [WIDTH-1:0] q_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [7:0]       wrap_cnt_o
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  if (WIDTH < 2) begin : g_wchk
    $error("WIDTH must be at least 2");
  end
  if (PRESCALE_DIV < 2) begin : g_pchk
    $error("PRESCALE_DIV must be at least 2");
  end

  state_t           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d, limit_q, limit_d;
  logic             mode_q, mode_d, done_q, done_d;
  logic [7:0]       wrap_q, wrap_d;
  logic             run, accept, tick;

  assign run    = state_q == RUN;
  assign accept = start_i & ~stop_i & ~run;

`ifdef PRESCALE_EN
  localparam int PW = $clog2(PRESCALE_DIV);
  logic [PW-1:0] pre_q, pre_d;
  assign tick = pre_q == PW'(PRESCALE_DIV - 1);
  // Prescaler advances only on unpaused RUN cycles, so pause freezes it.
  always_comb begin
    pre_d = pre_q;
    if (stop_i || accept) pre_d = '0;
    else if (run && !pause_i) pre_d = tick ? '0 : pre_q + PW'(1);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pre_q <= '0;
    else pre_q <= pre_d;
  end
`else
  assign tick = 1'b1;
`endif

  assign t_en_o     = run & ~pause_i & ~stop_i & tick;
  assign q_o        = q_q;
  assign busy_o     = run;
  assign done_o     = done_q;
  assign wrap_cnt_o = wrap_q;

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    limit_d = limit_q;
    mode_d  = mode_q;
    wrap_d  = wrap_q;
    done_d  = 1'b0;
    if (stop_i) begin
      state_d = IDLE;
      q_d     = '0;
    end else if (accept) begin
      limit_d = limit_i;
      mode_d  = auto_reload_i;
      q_d     = '0;
      wrap_d  = '0;
      state_d = (limit_i != '0) ? RUN : DONE;
      done_d  = limit_i == '0;
    end else if (t_en_o) begin
      // limit_q is nonzero whenever RUN is active, so limit_q-1 cannot underflow.
      if (q_q == limit_q - WIDTH'(1)) begin
        done_d  = 1'b1;
        q_d     = mode_q ? '0 : limit_q;
        state_d = mode_q ? RUN : DONE;
        wrap_d  = mode_q ? wrap_q + {7'd0, wrap_q != 8'hff} : wrap_q;
      end else begin
        q_d = q_q + WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      q_q     <= '0;
      limit_q <= '0;
      mode_q  <= 1'b0;
      done_q  <= 1'b0;
      wrap_q  <= '0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      limit_q <= limit_d;
      mode_q  <= mode_d;
      done_q  <= done_d;
      wrap_q  <= wrap_d;
    end
  end
endmodule
